ram_port_arbiter: RTL

- Shares one synchronous RAM port among 4 requesters, e.g. CPU, VGA reader, keyboard writer and a spare.
- Arbitration is round-robin. Each requester gets a req/ack handshake.
- Sits between the requesters and one port of the dual-port video/data RAM. That RAM port is clocked by clk, has 1-cycle read latency, and returns the write data on q during a write.
- At most one access is in flight at any time.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_pick4.sv | 28 ++
 rtl/ram_port_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the four-way RAM port arbiter.
// State encodings, requester count and the one-hot ack helper.
package ram_arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin pick among four masked requests.
// Searches upward from ptr, wrapping modulo 4.
module rr_pick4
    import ram_arb_pkg::*;
(
    input  logic [3:0] req_masked,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk from the farthest slot back so the nearest one overrides.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req_masked[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port among four requesters,
// round-robin, one access in flight, req/ack handshake.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        busy,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    output logic                        ram_we,
    input  logic [DATA_WIDTH-1:0]       ram_q
);

    arb_state_t state;
    logic [1:0] ptr;
    logic [1:0] idx;
    logic [3:0] eligible;
    logic       pick_valid;
    logic [1:0] pick_idx;

    // Mask the requester being acked so a late req drop is not re-served.
    assign eligible = req & ~ack;

    rr_pick4 u_pick (
        .req_masked (eligible),
        .ptr        (ptr),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        idx       <= pick_idx;
                        ram_addr  <= addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        ram_wdata <= wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                        ram_we    <= we[pick_idx];
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        ram_we <= 1'b0;
                    end
                end
                ISSUE: begin
                    ram_we <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    rdata <= ram_q;
                    ack   <= onehot4(idx);
                    ptr   <= idx + 2'd1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
